// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch stage and the multicycle controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } fetch_state_e;

  typedef enum logic {
    DEST_IR = 1'b0,
    DEST_TR = 1'b1
  } fetch_dest_e;

  // Opcode classes decoded from IR[7:5] by the controller
  localparam logic [2:0] OPC_JUMP   = 3'b110;
  localparam logic [2:0] OPC_DIRECT = 3'b111;

  function automatic logic [2:0] opc_class(input logic [7:0] ir_val);
    return ir_val[7:5];
  endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter register with load-over-increment priority, wrapping modulo 2^ADDR_W.
// Latency: load/increment visible the cycle after the strobe.
// Backpressure: none; strobes are qualified by the fetch FSM.
module pc_counter
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              inc_i,
  input  logic [ADDR_W-1:0] load_val_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Next PC: a jump load beats an increment; the adder wraps naturally
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + 1'b1;
    end
  end

  // PC register
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: runs controller strobes against a variable-latency byte memory; owns PC/IR/TR/DI.
// Latency: request accepted in N, req seen N+1, data visible the cycle after valid (min 2 cycles/fetch).
// Backpressure: busy high while a read is outstanding; FETCH_TIMEOUT_EN adds an abort after TIMEOUT_CYC waits.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_inc,
  input  logic              pc_or_tr,
  input  logic              ir_we,
  input  logic              tr_we,
  input  logic              pc_load_en,
  input  logic              di_load_en,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              mem_rd_valid,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] tr,
  output logic [4:0]        di,
  output logic [ADDR_W-1:0] jump_addr,
  output logic              busy,
  output logic              fetch_err
);

  fetch_state_e      state_q;
  fetch_dest_e       dest_q;
  logic              inc_q;
  logic              req_q;
  logic              busy_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] tr_q;
  logic [4:0]        di_q;

  logic [ADDR_W-1:0] pc_w;
  logic [ADDR_W-1:0] jump_w;
  logic [ADDR_W-1:0] fetch_addr_w;
  logic              start_w;
  logic              pc_load_d;
  logic              pc_inc_d;

  assign jump_w       = ADDR_W'({ir_q[4:0], tr_q});
  assign start_w      = ir_we | tr_we;
  // Address is taken from the pre-load PC even when pc_load_en fires in the same cycle
  assign fetch_addr_w = pc_or_tr ? pc_w : jump_w;

`ifdef FETCH_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q;
  logic             err_q;
  logic             tmo_hit_w;
  assign tmo_hit_w = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYC != 0);
`endif

  // PC strobes: controller requests only count in IDLE; in WAIT the PC moves only on a capture
  always_comb begin
    pc_load_d = 1'b0;
    pc_inc_d  = 1'b0;
    if (state_q == IDLE) begin
      pc_load_d = pc_load_en;
      pc_inc_d  = pc_inc & ~start_w;
    end else begin
      pc_inc_d  = mem_rd_valid & inc_q;
    end
  end

  pc_counter #(
    .ADDR_W(ADDR_W)
  ) u_pc (
    .clk       (clk),
    .rst       (rst),
    .load_i    (pc_load_d),
    .inc_i     (pc_inc_d),
    .load_val_i(jump_w),
    .pc_o      (pc_w)
  );

  // Fetch FSM with registered request/busy and destination capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dest_q  <= DEST_IR;
      inc_q   <= 1'b0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      addr_q  <= '0;
      ir_q    <= '0;
      tr_q    <= '0;
      di_q    <= '0;
`ifdef FETCH_TIMEOUT_EN
      tmo_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      if (di_load_en) begin
        di_q <= ir_q[4:0];
      end
      case (state_q)
        IDLE: begin
          if (start_w) begin
            state_q <= WAIT;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
            addr_q  <= fetch_addr_w;
            dest_q  <= ir_we ? DEST_IR : DEST_TR;
            // A simultaneous jump load already sets the PC; do not bump it afterwards
            inc_q   <= pc_inc & ~pc_load_en;
`ifdef FETCH_TIMEOUT_EN
            tmo_q   <= '0;
`endif
          end
        end
        WAIT: begin
          if (mem_rd_valid) begin
            if (dest_q == DEST_IR) begin
              ir_q <= mem_rd_data;
            end else begin
              tr_q <= mem_rd_data;
            end
            state_q <= IDLE;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (tmo_hit_w) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_rd_req = req_q;
  assign mem_addr   = addr_q;
  assign pc         = pc_w;
  assign ir         = ir_q;
  assign tr         = tr_q;
  assign di         = di_q;
  assign jump_addr  = jump_w;
  assign busy       = busy_q;
`ifdef FETCH_TIMEOUT_EN
  assign fetch_err  = err_q;
`else
  assign fetch_err  = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; honours FETCH_TIMEOUT_EN for the timeout scenario.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Memory responses are driven directly by the stimulus tasks.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_inc = 1'b0;
  logic        pc_or_tr = 1'b0;
  logic        ir_we = 1'b0;
  logic        tr_we = 1'b0;
  logic        pc_load_en = 1'b0;
  logic        di_load_en = 1'b0;
  logic [7:0]  mem_rd_data = 8'h00;
  logic        mem_rd_valid = 1'b0;
  logic        mem_rd_req;
  logic [12:0] mem_addr;
  logic [12:0] pc;
  logic [7:0]  ir;
  logic [7:0]  tr;
  logic [4:0]  di;
  logic [12:0] jump_addr;
  logic        busy;
  logic        fetch_err;

  int n_cmp = 0;
  int n_bad = 0;
  int busy_cnt;
  int req_cnt;
  logic [12:0] addr_seen;

  always #5 clk = ~clk;

  fetch_unit #(
    .ADDR_W(13),
    .DATA_W(8),
    .TIMEOUT_CYC(15)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_inc      (pc_inc),
    .pc_or_tr    (pc_or_tr),
    .ir_we       (ir_we),
    .tr_we       (tr_we),
    .pc_load_en  (pc_load_en),
    .di_load_en  (di_load_en),
    .mem_rd_data (mem_rd_data),
    .mem_rd_valid(mem_rd_valid),
    .mem_rd_req  (mem_rd_req),
    .mem_addr    (mem_addr),
    .pc          (pc),
    .ir          (ir),
    .tr          (tr),
    .di          (di),
    .jump_addr   (jump_addr),
    .busy        (busy),
    .fetch_err   (fetch_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full fetch: strobe for one cycle, hold valid low for 'waits' cycles, then one valid beat
  task automatic do_fetch(input bit iw, input bit tw, input bit inc, input bit sel,
                          input bit ld, input logic [7:0] d, input int waits);
    ir_we = iw; tr_we = tw; pc_inc = inc; pc_or_tr = sel; pc_load_en = ld;
    step();
    ir_we = 1'b0; tr_we = 1'b0; pc_inc = 1'b0; pc_or_tr = 1'b0; pc_load_en = 1'b0;
    addr_seen = mem_addr;
    busy_cnt = 0;
    for (int i = 0; i < waits; i++) begin
      if (busy) busy_cnt++;
      step();
    end
    if (busy) busy_cnt++;
    mem_rd_valid = 1'b1; mem_rd_data = d;
    step();
    mem_rd_valid = 1'b0; mem_rd_data = 8'h00;
    if (busy) busy_cnt++;
  endtask

  initial begin
    // Reset
    step();
    step();
    rst = 1'b0;
    chk("rst_pc", pc, 0);
    chk("rst_ir", ir, 0);
    chk("rst_tr", tr, 0);
    chk("rst_di", di, 0);
    chk("rst_req", mem_rd_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", fetch_err, 0);
    chk("rst_addr", mem_addr, 0);

    // Minimum-latency IR fetch with increment
    ir_we = 1'b1; pc_inc = 1'b1; pc_or_tr = 1'b1;
    step();
    ir_we = 1'b0; pc_inc = 1'b0; pc_or_tr = 1'b0;
    chk("t1_req", mem_rd_req, 1);
    chk("t1_addr", mem_addr, 13'h0000);
    chk("t1_pc_hold", pc, 0);
    chk("t1_ir_old", ir, 0);
    mem_rd_valid = 1'b1; mem_rd_data = 8'hC5;
    step();
    mem_rd_valid = 1'b0; mem_rd_data = 8'h00;
    chk("t1_ir", ir, 8'hC5);
    chk("t1_pc", pc, 1);
    chk("t1_busy_low", busy, 0);
    chk("t1_req_low", mem_rd_req, 0);

    // TR fetch with 3 wait cycles, then jump load
    do_fetch(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3A, 3);
    chk("t2_addr", addr_seen, 13'h0001);
    chk("t2_tr", tr, 8'h3A);
    chk("t2_busy_cyc", busy_cnt, 4);
    chk("t2_jump", jump_addr, 13'h053A);
    pc_load_en = 1'b1;
    step();
    pc_load_en = 1'b0;
    chk("t2_pc_load", pc, 13'h053A);

    // Reach PC 0x1FFF, then wrap; dual strobe writes IR only
    do_fetch(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 0);
    do_fetch(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF, 2);
    pc_load_en = 1'b1;
    step();
    pc_load_en = 1'b0;
    chk("t3_pc_max", pc, 13'h1FFF);
    do_fetch(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h77, 1);
    chk("t3_addr", addr_seen, 13'h1FFF);
    chk("t3_ir", ir, 8'h77);
    chk("t3_tr_kept", tr, 8'hFF);
    chk("t3_pc_wrap", pc, 13'h0000);

    // Reset during WAIT, then a stray valid
    ir_we = 1'b1; pc_or_tr = 1'b1;
    step();
    ir_we = 1'b0; pc_or_tr = 1'b0;
    chk("t4_req", mem_rd_req, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    mem_rd_valid = 1'b1; mem_rd_data = 8'hAA;
    step();
    mem_rd_valid = 1'b0; mem_rd_data = 8'h00;
    step();
    chk("t4_ir", ir, 0);
    chk("t4_tr", tr, 0);
    chk("t4_pc", pc, 0);
    chk("t4_req", mem_rd_req, 0);
    chk("t4_busy", busy, 0);
    chk("t4_addr", mem_addr, 0);

    // Memory that never answers
    ir_we = 1'b1; pc_or_tr = 1'b1;
    step();
    ir_we = 1'b0; pc_or_tr = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    req_cnt = 0;
    while (mem_rd_req && req_cnt < 40) begin
      req_cnt++;
      step();
    end
    chk("t5_req_cycles", req_cnt, 15);
    chk("t5_busy", busy, 0);
    chk("t5_err", fetch_err, 1);
    chk("t5_pc", pc, 0);
    chk("t5_ir", ir, 0);
    step();
    step();
    step();
    chk("t5_err_sticky", fetch_err, 1);
`else
    req_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (mem_rd_req) req_cnt++;
      step();
    end
    chk("t5_req_cycles", req_cnt, 100);
    chk("t5_err", fetch_err, 0);
    mem_rd_valid = 1'b1; mem_rd_data = 8'h00;
    step();
    mem_rd_valid = 1'b0;
    chk("t5_busy", busy, 0);
`endif

    // Immediate increments, DI load, jump load racing a fetch
    pc_inc = 1'b1;
    step();
    step();
    pc_inc = 1'b0;
    chk("t6_pc_inc", pc, 2);
    do_fetch(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hC5, 0);
    do_fetch(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h10, 0);
    chk("t6_jump", jump_addr, 13'h0510);
    di_load_en = 1'b1;
    step();
    di_load_en = 1'b0;
    chk("t6_di", di, 5'h05);
    do_fetch(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h21, 1);
    chk("t6_addr_old_pc", addr_seen, 13'h0002);
    chk("t6_pc_jump", pc, 13'h0510);
    chk("t6_ir", ir, 8'h21);
    chk("t6_jump2", jump_addr, 13'h0110);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
